// File: rtl/ioctl_loader_pkg.sv
// Shared types and default memory map for the ioctl download loader.
package ioctl_loader_pkg;

  localparam logic [24:0] DEFAULT_BIOS_BASE  = 25'h0000000;
  localparam logic [24:0] DEFAULT_BIOS_LIMIT = 25'h0100000;
  localparam logic [24:0] DEFAULT_RAM_BASE   = 25'h1000000;
  localparam logic [24:0] DEFAULT_RAM_LIMIT  = 25'h0200000;

  typedef enum logic [1:0] {
    REGION_NONE,
    REGION_BIOS,
    REGION_RAM
  } loader_region_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DRAIN
  } loader_state_t;

  typedef struct packed {
    logic [24:0] addr;
    logic [15:0] data;
  } loader_entry_t;

  function automatic loader_region_t decode_region(input logic [5:0] index);
    case (index)
      6'd0:    return REGION_BIOS;
      6'd1:    return REGION_RAM;
      default: return REGION_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ioctl_loader_fifo.sv
// Synchronous write-buffer FIFO of mapped loader entries; head is read combinationally.
module ioctl_loader_fifo
  import ioctl_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          push,
  input  loader_entry_t push_data,
  input  logic          pop,
  output loader_entry_t head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  loader_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // NOTE: every signal gets its default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; emptiness is tracked by the pointers/count, so stale data is never observed.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ioctl_loader.sv
// Maps the HPS ioctl download stream into buffered single-word SDRAM writes.
module ioctl_loader
  import ioctl_loader_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [24:0] BIOS_BASE  = DEFAULT_BIOS_BASE,
  parameter logic [24:0] BIOS_LIMIT = DEFAULT_BIOS_LIMIT,
  parameter logic [24:0] RAM_BASE   = DEFAULT_RAM_BASE,
  parameter logic [24:0] RAM_LIMIT  = DEFAULT_RAM_LIMIT
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  output logic        mem_req,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        bios_loaded,
  output logic        err
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  loader_state_t  state_q, state_d;
  loader_region_t region_q, region_d, wr_region;
  logic           download_q;
  logic           bios_loaded_q, bios_loaded_d;
  logic           err_q, err_d;
  logic           done_q, done_d;
  logic           wait_q, wait_d;
  logic           mem_req_q, mem_req_d;
  logic           dl_rise;
  logic [24:0]    wr_base, wr_limit;
  logic           push, pop;
  loader_entry_t  push_data, head;
  logic [CW-1:0]  count, count_nxt;
  logic           full, empty;
  logic           unused_index;

  assign unused_index = ^ioctl_index[7:6];

  ioctl_loader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    dl_rise = ioctl_download && !download_q;
    // A word arriving on the very cycle download rises must already use the new region.
    wr_region = dl_rise ? decode_region(ioctl_index[5:0]) : region_q;
    wr_base  = '0;
    wr_limit = '0;
    case (wr_region)
      REGION_BIOS: begin wr_base = BIOS_BASE; wr_limit = BIOS_LIMIT; end
      REGION_RAM:  begin wr_base = RAM_BASE;  wr_limit = RAM_LIMIT;  end
      default:     ;
    endcase

    push  = 1'b0;
    err_d = err_q;
    if (ioctl_wr && ioctl_download && wr_region != REGION_NONE) begin
      if (ioctl_addr[0] || ioctl_addr >= wr_limit || full) err_d = 1'b1;
      else                                                  push  = 1'b1;
    end
    push_data = '{addr: wr_base + ioctl_addr, data: ioctl_dout};

    pop       = mem_req_q && mem_ack;
    count_nxt = count + CW'(push) - CW'(pop);
    mem_req_d = mem_req_q ? (count_nxt != '0) : !empty;

    state_d       = state_q;
    region_d      = region_q;
    done_d        = 1'b0;
    bios_loaded_d = bios_loaded_q;
    case (state_q)
      ST_IDLE: begin
        if (dl_rise) begin
          state_d  = ST_ACTIVE;
          region_d = wr_region;
          if (wr_region == REGION_BIOS) bios_loaded_d = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (!ioctl_download) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // A restart abandons the earlier download's completion; queued entries keep their addresses.
        if (dl_rise) begin
          state_d  = ST_ACTIVE;
          region_d = wr_region;
          if (wr_region == REGION_BIOS) bios_loaded_d = 1'b0;
        end else if (empty && !mem_req_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (region_q == REGION_BIOS) bios_loaded_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    wait_d = (state_d != ST_IDLE) && (count_nxt >= CW'(FIFO_DEPTH - 1));
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      region_q      <= REGION_NONE;
      download_q    <= 1'b0;
      bios_loaded_q <= 1'b0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
      wait_q        <= 1'b0;
      mem_req_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      region_q      <= region_d;
      download_q    <= ioctl_download;
      bios_loaded_q <= bios_loaded_d;
      err_q         <= err_d;
      done_q        <= done_d;
      wait_q        <= wait_d;
      mem_req_q     <= mem_req_d;
    end
  end

  assign ioctl_wait  = wait_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_req_q ? head.addr : '0;
  assign mem_din     = mem_req_q ? head.data : '0;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign bios_loaded = bios_loaded_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ioctl_loader.sv
// Directed self-checking bench for ioctl_loader with a simple SDRAM acknowledge model.
module tb_ioctl_loader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait;
  logic        mem_req;
  logic [24:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic        bios_loaded;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [40:0] wlog [$];
  logic [40:0] exp_q [$];
  int          log_base;
  int          done_cnt = 0;
  int          req_cycles = 0;
  logic        ack_hold = 1'b0;
  int          ack_delay = 3;

  ioctl_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_ack        (mem_ack),
    .busy           (busy),
    .done           (done),
    .bios_loaded    (bios_loaded),
    .err            (err)
  );

  initial forever #5 clk_sys = ~clk_sys;

  // SDRAM controller model: acknowledges a held request ack_delay cycles after it is seen.
  initial begin
    int req_age;
    req_age = 0;
    mem_ack = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      mem_ack = 1'b0;
      if (mem_req && !ack_hold) begin
        req_age++;
        if (req_age >= ack_delay) begin
          mem_ack = 1'b1;
          wlog.push_back({mem_addr, mem_din});
          req_age = 0;
        end
      end else begin
        req_age = 0;
      end
    end
  end

  always @(negedge clk_sys) begin
    if (done)    done_cnt   <= done_cnt + 1;
    if (mem_req) req_cycles <= req_cycles + 1;
  end

  task automatic check(input string tag, input logic [40:0] obs, input logic [40:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic host_write(input logic [24:0] a, input logic [15:0] d);
    int guard;
    guard = 0;
    while (ioctl_wait && guard < 100) begin
      tick(1);
      guard++;
    end
    if (guard >= 100) check("host wait bound", {40'd0, ioctl_wait}, 41'd0);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick(1);
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < 300) begin
      tick(1);
      n++;
    end
    tick(2);
    check(tag, 41'(done_cnt - start), 41'd1);
  endtask

  task automatic check_log(input string tag);
    check({tag, " count"}, 41'(wlog.size() - log_base), 41'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (log_base + i < wlog.size())
        check($sformatf("%s[%0d]", tag, i), wlog[log_base + i], exp_q[i]);
    end
  endtask

  initial begin
    int req_base;
    int done_base;
    ioctl_index = 8'd0;
    ioctl_addr  = '0;
    ioctl_dout  = '0;
    do_reset();

    check("rst mem_req", {40'd0, mem_req}, 41'd0);
    check("rst wait", {40'd0, ioctl_wait}, 41'd0);
    check("rst busy", {40'd0, busy}, 41'd0);
    check("rst done", {40'd0, done}, 41'd0);
    check("rst bios", {40'd0, bios_loaded}, 41'd0);
    check("rst err", {40'd0, err}, 41'd0);
    check("rst addr", {16'd0, mem_addr}, 41'd0);

    // Index 0: four words, acknowledged 3 cycles after each request.
    log_base = wlog.size();
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    tick(1);
    check("A busy", {40'd0, busy}, 41'd1);
    host_write(25'h0, 16'h1234);
    check("A latency req low", {40'd0, mem_req}, 41'd0);
    tick(1);
    check("A latency req high", {40'd0, mem_req}, 41'd1);
    check("A first addr", {16'd0, mem_addr}, 41'h0);
    check("A first data", {25'd0, mem_din}, 41'h1234);
    host_write(25'h2, 16'h5678);
    host_write(25'h4, 16'h9ABC);
    host_write(25'h6, 16'hDEF0);
    ioctl_download = 1'b0;
    wait_done("A done pulse");
    exp_q = '{{25'h0000000, 16'h1234}, {25'h0000002, 16'h5678},
              {25'h0000004, 16'h9ABC}, {25'h0000006, 16'hDEF0}};
    check_log("A writes");
    check("A bios", {40'd0, bios_loaded}, 41'd1);
    check("A err", {40'd0, err}, 41'd0);
    check("A idle", {40'd0, busy}, 41'd0);

    // Index 1: back-to-back writes with acknowledges withheld.
    log_base = wlog.size();
    ack_hold = 1'b1;
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(2 * i);
      ioctl_dout = 16'(16'h1111 * (i + 1));
      tick(1);
      if (i == 1) check("B wait at 2", {40'd0, ioctl_wait}, 41'd0);
      if (i == 2) check("B wait at 3", {40'd0, ioctl_wait}, 41'd1);
    end
    ioctl_wr = 1'b0;
    tick(20);
    check("B held req", {40'd0, mem_req}, 41'd1);
    check("B held addr", {16'd0, mem_addr}, 41'h1000000);
    check("B held data", {25'd0, mem_din}, 41'h1111);
    check("B wait full", {40'd0, ioctl_wait}, 41'd1);
    check("B no writes yet", 41'(wlog.size() - log_base), 41'd0);
    ack_hold = 1'b0;
    ioctl_download = 1'b0;
    wait_done("B done pulse");
    exp_q = '{{25'h1000000, 16'h1111}, {25'h1000002, 16'h2222},
              {25'h1000004, 16'h3333}, {25'h1000006, 16'h4444}};
    check_log("B writes");
    check("B err", {40'd0, err}, 41'd0);
    check("B bios kept", {40'd0, bios_loaded}, 41'd1);

    // Index 5 (high bits set too): silently discarded, still completes.
    log_base = wlog.size();
    req_base = req_cycles;
    ioctl_index = 8'hC5;
    ioctl_download = 1'b1;
    tick(1);
    host_write(25'h0, 16'h5555);
    ioctl_download = 1'b0;
    wait_done("C done pulse");
    check("C no req", 41'(req_cycles - req_base), 41'd0);
    check("C err", {40'd0, err}, 41'd0);

    // Odd address under index 1 is dropped.
    req_base = req_cycles;
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    tick(1);
    host_write(25'h3, 16'h0BAD);
    tick(4);
    check("D odd err", {40'd0, err}, 41'd1);
    check("D odd no req", 41'(req_cycles - req_base), 41'd0);
    ioctl_download = 1'b0;
    wait_done("D odd done");

    // Limit boundary: last legal word accepted, first word at limit dropped.
    do_reset();
    check("D2 err cleared", {40'd0, err}, 41'd0);
    log_base = wlog.size();
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    tick(1);
    host_write(25'h10, 16'hA5A5);
    host_write(25'h1FFFFE, 16'h5A5A);
    check("D2 below limit err", {40'd0, err}, 41'd0);
    host_write(25'h200000, 16'hBEEF);
    check("D2 at limit err", {40'd0, err}, 41'd1);
    ioctl_download = 1'b0;
    wait_done("D2 done");
    exp_q = '{{25'h1000010, 16'hA5A5}, {25'h11FFFFE, 16'h5A5A}};
    check_log("D2 writes");

    // Fifth word forced into a full FIFO is dropped; queued entries survive.
    do_reset();
    log_base = wlog.size();
    ack_hold = 1'b1;
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(2 * i);
      ioctl_dout = 16'(16'hE000 + i);
      tick(1);
    end
    ioctl_wr = 1'b0;
    check("E full err", {40'd0, err}, 41'd1);
    check("E head addr", {16'd0, mem_addr}, 41'h0);
    check("E head data", {25'd0, mem_din}, 41'hE000);
    ack_hold = 1'b0;
    ioctl_download = 1'b0;
    wait_done("E done");
    exp_q = '{{25'h0, 16'hE000}, {25'h2, 16'hE001}, {25'h4, 16'hE002}, {25'h6, 16'hE003}};
    check_log("E writes");
    check("E bios", {40'd0, bios_loaded}, 41'd1);

    // Reset while a request is held with three entries queued.
    ack_hold = 1'b1;
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    tick(1);
    check("F bios cleared on start", {40'd0, bios_loaded}, 41'd0);
    for (int i = 0; i < 3; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(2 * i);
      ioctl_dout = 16'(16'hF000 + i);
      tick(1);
    end
    ioctl_wr = 1'b0;
    tick(1);
    check("F req before reset", {40'd0, mem_req}, 41'd1);
    done_base = done_cnt;
    reset = 1'b1;
    tick(1);
    check("F req after reset", {40'd0, mem_req}, 41'd0);
    check("F busy after reset", {40'd0, busy}, 41'd0);
    check("F bios after reset", {40'd0, bios_loaded}, 41'd0);
    check("F wait after reset", {40'd0, ioctl_wait}, 41'd0);
    reset = 1'b0;
    ioctl_download = 1'b0;
    ack_hold = 1'b0;
    req_base = req_cycles;
    tick(6);
    check("F no done", 41'(done_cnt - done_base), 41'd0);
    check("F fifo empty", 41'(req_cycles - req_base), 41'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ioctl_loader.md
Name: ioctl_loader

Overview:
- Core-side responder for the HPS ioctl download stream.
- Accepts 16-bit words from ioctl_wr, maps ioctl_index/ioctl_addr into an SDRAM byte address, buffers them in a small FIFO and issues single-word SDRAM write requests.
- Throttles the host with ioctl_wait.
- Sits inside pcfx_top between the ioctl port and an sdram controller write client; reports load completion to the machine reset logic.

Parameters:
- FIFO_DEPTH, 4, word entries in the write buffer; power of two, minimum 2.
- BIOS_BASE, 25'h0000000, SDRAM base for index 0 (ROM BIOS).
- BIOS_LIMIT, 25'h0100000, BIOS region size in bytes (1 MiB).
- RAM_BASE, 25'h1000000, SDRAM base for index 1 (RAM image).
- RAM_LIMIT, 25'h0200000, RAM image region size in bytes (2 MiB).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  high for the duration of a download.
- ioctl_index  in  8  download target; bits [5:0] select the region, bits [7:6] are ignored.
- ioctl_wr  in  1  one-cycle strobe: word valid.
- ioctl_addr  in  25  byte offset of the word within the download.
- ioctl_dout  in  16  data word.
- ioctl_wait  out  1  host must not advance while high.
- mem_req  out  1  write request, level-held until acknowledged.
- mem_addr  out  25  SDRAM byte address, even.
- mem_din  out  16  write data.
- mem_ack  in  1  one-cycle acknowledge from the SDRAM controller.
- busy  out  1  download active or buffer not drained.
- done  out  1  one-cycle pulse: download finished and all words written.
- bios_loaded  out  1  sticky: index 0 completed since reset.
- err  out  1  sticky: a word was dropped.

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE.
- Reset mid-operation flushes the FIFO and drops mem_req on the next edge; the SDRAM controller tolerates request withdrawal.
- Index latching: ioctl_index is latched on the rising edge of ioctl_download.
  - Index 0 maps to base BIOS_BASE, limit BIOS_LIMIT.
  - Index 1 maps to base RAM_BASE, limit RAM_LIMIT.
  - Any other index is the NONE region: words are accepted and discarded silently, with no err.
- Enqueue: on ioctl_wr with download high, the entry {base + ioctl_addr, ioctl_dout} is pushed in the same cycle.
- Drop conditions. The word is dropped and err is set if any of these holds:
  - ioctl_addr[0] = 1;
  - ioctl_addr >= limit;
  - the FIFO is full (host violated ioctl_wait).
- ioctl_wr with download low is ignored.
- ioctl_wait is registered; it is high whenever the FIFO count after this cycle's push and pop is >= FIFO_DEPTH-1. It is low in IDLE.
- Issue latency: the head entry drives mem_addr/mem_din with mem_req=1 on the cycle after the FIFO goes non-empty, i.e. ioctl_wr at edge N gives mem_req high after edge N+1.
- Request hold: mem_addr/mem_din stay stable while mem_req is high.
- Acknowledge: on mem_ack the entry is popped.
  - mem_req falls at the next edge if the FIFO then becomes empty.
  - Otherwise mem_req stays high and presents the next entry; the address changes at that edge.
- mem_ack while mem_req is low is ignored.
- Simultaneous push and pop: the count is unchanged and both are applied.
- State machine:
  - IDLE: on download rising, latch the index, clear err if desired (err is cleared only by reset), go to ACTIVE.
  - ACTIVE: busy=1; on download falling, go to DRAIN.
  - DRAIN: busy=1.
    - When the FIFO is empty and mem_req=0, pulse done for one cycle, set bios_loaded if the region is BIOS, go to IDLE.
    - If download rises again in DRAIN, re-latch the index, go to ACTIVE, and suppress done for the earlier download. Queued entries keep their already-mapped addresses.
- Address arithmetic: 25-bit unsigned, no wrap. Sums beyond 25 bits cannot occur within the limits.
- bios_loaded is cleared when a new index-0 download starts.

Decomposition:
- core_pkg additions:
  - loader_region_t enum (REGION_NONE, REGION_BIOS, REGION_RAM);
  - typedef loader_entry_t struct {addr[24:0], data[15:0]};
  - default BASE/LIMIT constants.
- One sub-module, ioctl_loader_fifo: synchronous FIFO of loader_entry_t with push, pop, count, full and empty, depth FIFO_DEPTH, same clk_sys/reset.

Test Plan:
- Index 0 download of 4 words at addr 0,2,4,6, data 16'h1234,5678,9ABC,DEF0, mem_ack 3 cycles after each req -> mem writes at 0x0000000..0x0000006 with matching data in order; one done pulse after the last ack; bios_loaded=1; err=0.
- Back-to-back ioctl_wr every cycle, mem_ack withheld 20 cycles -> ioctl_wait high once count reaches 3; no word lost; all 4 writes delivered after acks resume.
- Index 1, addr 0x10 -> mem_addr 0x1000010; addr 0x200000 -> word dropped, err=1, no mem_req.
- Odd ioctl_addr 0x3 -> dropped, err=1. Index 5 word -> no mem_req, err stays 0, done still pulses.
- ioctl_wr forced while FIFO full -> word dropped, err=1, queued entries intact.
- Reset asserted while mem_req high with 3 entries queued -> next edge: mem_req=0, busy=0, FIFO empty, no done, bios_loaded=0.
